// File: rtl/keypad_pkg.sv
// Types and helpers shared between the keypad debouncer and the keyscan FSM.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HELD,
        RELEASE
    } db_state_t;

    // True when exactly one bit of x is set.
    function automatic logic is_onehot4(input logic [3:0] x);
        return (x != 4'b0000) && ((x & (x - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Signals exchanged between the keypad/keyscan side (master) and the debouncer (slave).
interface key_debouncer_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] col_raw;
    logic [NUM_ROWS-1:0] row_pressed;
    logic                debounce_en;
    logic [NUM_COLS-1:0] col_sync;
    logic                debounced;
    logic                key_valid;
    logic [NUM_ROWS-1:0] key_row;
    logic [NUM_COLS-1:0] key_col;

    modport master (
        output col_raw, row_pressed, debounce_en,
        input  col_sync, debounced, key_valid, key_row, key_col
    );

    modport slave (
        input  col_raw, row_pressed, debounce_en,
        output col_sync, debounced, key_valid, key_row, key_col
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // NOTE: non-blocking assignments let meta and q update together on the edge,
    // forming a real two-stage pipeline instead of collapsing into one flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Qualifies a single-column key press and its release over DB_CYCLES stable clocks,
// then presents a debounced level, a one-cycle key_valid pulse and the latched row/column.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DB_CYCLES = 240000,
    parameter int CNT_W     = 18
) (
    input  logic            clk,
    input  logic            reset,
    key_debouncer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NUM_COLS-1:0] col_sync;

    db_state_t           state,     state_nx;
    logic [CNT_W-1:0]    cnt,       cnt_nx;
    logic [NUM_ROWS-1:0] cap_row,   cap_row_nx;
    logic [NUM_COLS-1:0] cap_col,   cap_col_nx;
    logic                debounced, debounced_nx;
    logic                key_valid, key_valid_nx;
    logic [NUM_ROWS-1:0] key_row,   key_row_nx;
    logic [NUM_COLS-1:0] key_col,   key_col_nx;

    sync_2ff #(.W(NUM_COLS)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.col_raw),
        .q     (col_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_row   <= '0;
            cap_col   <= '0;
            debounced <= 1'b0;
            key_valid <= 1'b0;
            key_row   <= '0;
            key_col   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cap_row   <= cap_row_nx;
            cap_col   <= cap_col_nx;
            debounced <= debounced_nx;
            key_valid <= key_valid_nx;
            key_row   <= key_row_nx;
            key_col   <= key_col_nx;
        end
    end

    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cap_row_nx   = cap_row;
        cap_col_nx   = cap_col;
        debounced_nx = debounced;
        key_valid_nx = 1'b0;
        key_row_nx   = key_row;
        key_col_nx   = key_col;

        unique case (state)
            IDLE: begin
                if (bus.debounce_en && is_onehot4(col_sync)) begin
                    cap_col_nx = col_sync;
                    cap_row_nx = bus.row_pressed;
                    cnt_nx     = '0;
                    state_nx   = COUNT;
                end
            end
            COUNT: begin
                if (!bus.debounce_en || (col_sync != cap_col)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx       = '0;
                    state_nx     = HELD;
                    debounced_nx = 1'b1;
                    key_valid_nx = 1'b1;
                    key_row_nx   = cap_row;
                    key_col_nx   = cap_col;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (col_sync != cap_col) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (col_sync == cap_col) begin
                    state_nx = HELD;
                end else if (col_sync != '0) begin
                    // A different key is down, so this is not a release yet.
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx       = '0;
                    state_nx     = IDLE;
                    debounced_nx = 1'b0;
                    key_row_nx   = '0;
                    key_col_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.col_sync  = col_sync;
    assign bus.debounced = debounced;
    assign bus.key_valid = key_valid;
    assign bus.key_row   = key_row;
    assign bus.key_col   = key_col;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with DB_CYCLES=4: directed stimulus, key_valid pulses
// checked against a scoreboard of expected (row, col, cycle) entries.
module tb_key_debouncer;
    import keypad_pkg::*;

    localparam int DB = 4;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    key_debouncer_if bus ();

    key_debouncer #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every key_valid pulse must match the oldest expected press.
    always @(negedge clk) begin
        if (bus.key_valid) begin
            if (sb.size() == 0) begin
                check("kv_unexpected", bus.key_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("kv_cycle", cyc, mon_e.at);
                check("kv_row", bus.key_row, mon_e.row);
                check("kv_col", bus.key_col, mon_e.col);
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            mon_e = sb.pop_front();
            check("kv_missing", bus.key_valid, 1);
        end
    end

    initial begin
        int e;
        bus.col_raw     = 4'b0100;
        bus.row_pressed = 4'b0000;
        bus.debounce_en = 1'b0;

        // Reset held with a column active
        #23;
        check("rst_col_sync", bus.col_sync, 4'b0000);
        check("rst_debounced", bus.debounced, 0);
        check("rst_key_valid", bus.key_valid, 0);
        check("rst_key_row", bus.key_row, 4'b0000);
        check("rst_key_col", bus.key_col, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b1;
        step(2);
        check("sync_after_2", bus.col_sync, 4'b0100);
        step(3);
        check("no_en_no_press", bus.debounced, 0);
        bus.col_raw = 4'b0000;
        step(4);

        // Clean press and release
        e = cyc;
        bus.row_pressed = 4'b0010;
        bus.debounce_en = 1'b1;
        bus.col_raw     = 4'b0001;
        sb.push_back('{row: 4'b0010, col: 4'b0001, at: e + 7});
        step(6);
        check("clean_pre", bus.debounced, 0);
        step(1);
        check("clean_deb", bus.debounced, 1);
        check("clean_row", bus.key_row, 4'b0010);
        check("clean_col", bus.key_col, 4'b0001);
        step(1);
        check("clean_kv_pulse", bus.key_valid, 0);
        bus.col_raw     = 4'b0000;
        bus.debounce_en = 1'b0;
        step(6);
        check("clean_rel_hold", bus.debounced, 1);
        step(1);
        check("clean_rel", bus.debounced, 0);
        check("clean_rel_row", bus.key_row, 4'b0000);
        check("clean_rel_col", bus.key_col, 4'b0000);

        // Bounce on press: last change (to 0001) at e+8
        e = cyc;
        bus.row_pressed = 4'b0100;
        bus.debounce_en = 1'b1;
        sb.push_back('{row: 4'b0100, col: 4'b0001, at: e + 15});
        for (int i = 0; i < 5; i++) begin
            bus.col_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            step(2);
            check("bounce_low", bus.debounced, 0);
        end
        step(5);
        check("bounce_deb", bus.debounced, 1);
        check("bounce_col", bus.key_col, 4'b0001);
        bus.col_raw     = 4'b0000;
        bus.debounce_en = 1'b0;
        step(7);
        check("bounce_rel", bus.debounced, 0);

        // Release bounce
        e = cyc;
        bus.row_pressed = 4'b1000;
        bus.debounce_en = 1'b1;
        bus.col_raw     = 4'b0010;
        sb.push_back('{row: 4'b1000, col: 4'b0010, at: e + 7});
        step(7);
        check("rb_deb", bus.debounced, 1);
        bus.debounce_en = 1'b0;
        bus.col_raw     = 4'b0000;
        step(2);
        check("rb_gap1", bus.debounced, 1);
        bus.col_raw = 4'b0010;
        step(1);
        check("rb_back", bus.debounced, 1);
        bus.col_raw = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("rb_hold", bus.debounced, 1);
        end
        step(1);
        check("rb_fall", bus.debounced, 0);

        // Multiple columns never qualify
        bus.debounce_en = 1'b1;
        bus.col_raw     = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step(5);
            check("multi_deb", bus.debounced, 0);
            check("multi_kv", bus.key_valid, 0);
        end
        bus.col_raw     = 4'b0000;
        bus.debounce_en = 1'b0;
        step(4);

        // Abort during COUNT, then re-qualify with a row change after capture
        bus.row_pressed = 4'b0001;
        bus.col_raw     = 4'b0100;
        bus.debounce_en = 1'b1;
        step(5);
        bus.debounce_en = 1'b0;
        step(8);
        check("abort_deb", bus.debounced, 0);
        e = cyc;
        bus.debounce_en = 1'b1;
        sb.push_back('{row: 4'b0001, col: 4'b0100, at: e + 5});
        step(2);
        bus.row_pressed = 4'b1000;
        step(3);
        check("requal_deb", bus.debounced, 1);
        check("requal_row", bus.key_row, 4'b0001);
        check("requal_col", bus.key_col, 4'b0100);

        // Asynchronous reset while HELD
        step(2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_deb", bus.debounced, 0);
        check("arst_row", bus.key_row, 4'b0000);
        check("arst_col", bus.key_col, 4'b0000);
        check("arst_sync", bus.col_sync, 4'b0000);
        bus.col_raw     = 4'b0000;
        bus.debounce_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(4);
        check("post_rst_deb", bus.debounced, 0);

        step(3);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Sits between the keypad column pins and the keyscan FSM.
- Synchronizes the raw column inputs and, when keyscan requests it (debounce_en), checks that one column stays stable for DB_CYCLES clocks.
- Then asserts the debounced level that keyscan consumes, and latches the pressed row/column pair for downstream decode.
- Holds debounced high until the key has been fully released for DB_CYCLES clocks, so keyscan never re-triggers on bounce.

Parameters:
- DB_CYCLES, 240000: stable clocks required for press and for release (5 ms at 48 MHz); must be >= 2.
- CNT_W, 18: counter width; must satisfy 2^CNT_W >= DB_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- col_raw  input  4  raw keypad columns, active-high, asynchronous to clk.
- row_pressed  input  4  one-hot row currently driven by keyscan.
- debounce_en  input  1  keyscan request to qualify the current press.
- col_sync  output  4  2-flop synchronized columns; keyscan uses these for col.
- debounced  output  1  level; high while a qualified key is held or its release is being qualified.
- key_valid  output  1  one-cycle pulse on the cycle debounced rises.
- key_row  output  4  row latched at press start; valid while debounced=1.
- key_col  output  4  column latched at press start; valid while debounced=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset).
- Reset: all outputs 0, state IDLE, counter 0, synchronizer flops 0. Reset asserted mid-operation returns to IDLE at once, regardless of state.
- Synchronizer: col_sync = col_raw delayed by 2 clk edges. All FSM decisions use col_sync only.
- onehot(x): x != 0 and (x & (x-1)) == 0.
- IDLE, debounced=0:
  - If debounce_en and onehot(col_sync): capture cap_col <= col_sync, cap_row <= row_pressed, cnt <= 0, go to COUNT.
  - Zero or multiple columns pressed: stay in IDLE.
- COUNT:
  - If debounce_en=0 or col_sync != cap_col: go to IDLE, cnt <= 0.
  - Else if cnt == DB_CYCLES-1: go to HELD, and debounced, key_valid, key_row, key_col are registered high/valid on the same edge.
  - Else cnt++.
  - COUNT therefore lasts exactly DB_CYCLES cycles.
- HELD, debounced=1:
  - debounce_en is ignored.
  - If col_sync != cap_col: go to RELEASE, cnt <= 0.
- RELEASE, debounced=1:
  - If col_sync == cap_col: return to HELD (bounce on release).
  - If col_sync is nonzero and != cap_col: cnt <= 0, stay (other key held; not released).
  - If col_sync == 0 and cnt == DB_CYCLES-1: go to IDLE; debounced, key_row, key_col clear on that edge.
  - Else cnt++.
- Latency: col_raw stable from edge e gives col_sync at e+2, IDLE→COUNT at e+3, debounced=1 at e+3+DB_CYCLES. Release takes the same latency to debounced=0.
- key_valid is high exactly one cycle per qualified press and never in any other state.
- Counter never wraps: it is compared to DB_CYCLES-1 and cleared before incrementing past it.
- A change of row_pressed after capture is ignored; key_row keeps the captured value.

Decomposition:
- keypad_pkg:
  - enum db_state_t {IDLE, COUNT, HELD, RELEASE}
  - function is_onehot4
  - localparam NUM_ROWS=4 and NUM_COLS=4, shared with keyscan.
- Sub-module sync_2ff (parameter W=4, async active-low reset) implements the column synchronizer.

Test Plan (DB_CYCLES=4, CNT_W=3):
- Reset: hold reset=0 with col_raw=4'b0100 → all outputs 0. Release reset → col_sync=4'b0100 after 2 edges, debounced stays 0 while debounce_en=0.
- Clean press: row_pressed=4'b0010, debounce_en=1, col_raw=4'b0001 from edge e → debounced=1 and key_valid pulse at e+7, key_row=4'b0010, key_col=4'b0001. Release col_raw=0 → debounced=0 at release edge+7.
- Bounce on press: col_raw toggles 0001/0000 every 2 cycles for 10 cycles, then holds 0001 → no key_valid during bouncing; single key_valid 7 edges after the final stable edge.
- Multi-key: col_raw=4'b0011 with debounce_en=1 → state stays IDLE, debounced=0, key_valid=0 indefinitely.
- Release bounce: from HELD, col_raw=0 for 2 cycles, back to 0001 for 1 cycle, then 0 → debounced stays 1 throughout and falls only 7 edges after the final 0.
- Abort and reset: debounce_en drops during COUNT → IDLE with no key_valid. Separately, assert reset in HELD → debounced, key_row, key_col go to 0 immediately, without waiting for a clock edge.
